// File: rtl/motor_pkg.sv
// Shared widths and per-side status encoding for the motor PWM decoder.
package motor_pkg;
  localparam int CMD_W = 11;
  localparam int MAG_W = 10;

  typedef enum logic [1:0] {ST_OK, ST_BRAKE, ST_IDLE, ST_FAULT} mot_stat_t;
endpackage

// File: rtl/pwm_side_decode.sv
// One motor side: fwd/rev high-time counters over a frame and the
// signed-magnitude decode registered at frame end.
module pwm_side_decode
  import motor_pkg::*;
#(
  parameter int PERIOD_BITS = MAG_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 fwd_i,
  input  logic                 rev_i,
  input  logic                 frame_end_i,
  output logic [PERIOD_BITS:0] cmd_o,
  output logic [1:0]           stat_o
);

  localparam int CW = PERIOD_BITS + 1;
  localparam logic [CW-1:0] FULL = CW'(1) << PERIOD_BITS;

  logic [CW-1:0] hf_q, hr_q;
  logic [CW-1:0] hf_tot, hr_tot;
  logic [CW-1:0] cmd_q, cmd_d;
  mot_stat_t     stat_q, stat_d;

  // The frame-end sample is part of the frame, so decode on the totals.
  assign hf_tot = hf_q + CW'(fwd_i);
  assign hr_tot = hr_q + CW'(rev_i);

  function automatic logic [PERIOD_BITS-1:0] sat_mag(input logic [CW-1:0] v);
    return v[PERIOD_BITS] ? '1 : v[PERIOD_BITS-1:0];
  endfunction

  always_comb begin
    cmd_d  = cmd_q;
    stat_d = ST_FAULT;
    if (hf_tot == FULL && hr_tot == FULL) begin
      cmd_d  = '0;
      stat_d = ST_BRAKE;
    end else if (hf_tot == '0 && hr_tot == '0) begin
      cmd_d  = '0;
      stat_d = ST_IDLE;
    end else if (hr_tot == '0) begin
      cmd_d  = {1'b0, sat_mag(hf_tot)};
      stat_d = ST_OK;
    end else if (hf_tot == '0) begin
      cmd_d  = {1'b1, sat_mag(hr_tot)};
      stat_d = ST_OK;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hf_q   <= '0;
      hr_q   <= '0;
      cmd_q  <= '0;
      stat_q <= ST_OK;
    end else if (frame_end_i) begin
      hf_q   <= '0;
      hr_q   <= '0;
      cmd_q  <= cmd_d;
      stat_q <= stat_d;
    end else begin
      hf_q   <= hf_tot;
      hr_q   <= hr_tot;
    end
  end

  assign cmd_o  = cmd_q;
  assign stat_o = stat_q;

endmodule

// File: rtl/motor_pwm_decode.sv
// Motor H-bridge pin monitor: recovers lft/rht signed-magnitude commands per
// 2^PERIOD_BITS frame. Define MOTOR_DEC_SYNC_EN to add 2-flop pin synchronizers.
module motor_pwm_decode
  import motor_pkg::*;
#(
  parameter int PERIOD_BITS = MAG_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 fwd_lft,
  input  logic                 rev_lft,
  input  logic                 fwd_rht,
  input  logic                 rev_rht,
  output logic [PERIOD_BITS:0] lft,
  output logic [PERIOD_BITS:0] rht,
  output logic [1:0]           lft_stat,
  output logic [1:0]           rht_stat,
  output logic                 vld
);

  logic [3:0]             pins_raw, pins;
  logic [PERIOD_BITS-1:0] frm_cnt_q;
  logic                   frame_end;
  logic                   vld_q;

  assign pins_raw = {rev_rht, fwd_rht, rev_lft, fwd_lft};

`ifdef MOTOR_DEC_SYNC_EN
  logic [3:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= pins_raw;
      sync2_q <= sync1_q;
    end
  end

  assign pins = sync2_q;
`else
  assign pins = pins_raw;
`endif

  assign frame_end = &frm_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frm_cnt_q <= '0;
      vld_q     <= 1'b0;
    end else begin
      frm_cnt_q <= frm_cnt_q + 1'b1;
      vld_q     <= frame_end;
    end
  end

  pwm_side_decode #(.PERIOD_BITS(PERIOD_BITS)) u_lft (
    .clk         (clk),
    .rst_n       (rst_n),
    .fwd_i       (pins[0]),
    .rev_i       (pins[1]),
    .frame_end_i (frame_end),
    .cmd_o       (lft),
    .stat_o      (lft_stat)
  );

  pwm_side_decode #(.PERIOD_BITS(PERIOD_BITS)) u_rht (
    .clk         (clk),
    .rst_n       (rst_n),
    .fwd_i       (pins[2]),
    .rev_i       (pins[3]),
    .frame_end_i (frame_end),
    .cmd_o       (rht),
    .stat_o      (rht_stat)
  );

  assign vld = vld_q;

endmodule

// File: doc/motor_pwm_decode.md
# motor_pwm_decode

Recovers the signed-magnitude drive commands from the four motor H-bridge pins (fwd/rev per side) by measuring PWM high time over fixed 1024-cycle frames. It is the inverse of the motor controller's PWM generation and sits on the motor pins as an on-chip monitor and self-check. Once per frame it reports the reconstructed 11-bit `lft`/`rht` commands and a per-side status.

## Interface
- `PERIOD_BITS`, default 10: frame length is 2^PERIOD_BITS clocks. Must match the PWM generator's counter width.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous active-low reset.
- `fwd_lft` in 1: left forward pin.
- `rev_lft` in 1: left reverse pin.
- `fwd_rht` in 1: right forward pin.
- `rev_rht` in 1: right reverse pin.
- `lft` out 11: decoded left command; bit 10 = reverse, [9:0] = magnitude.
- `rht` out 11: decoded right command; same format as `lft`.
- `lft_stat` out 2: left status: 0 = OK, 1 = BRAKE, 2 = IDLE, 3 = FAULT.
- `rht_stat` out 2: right status; same encoding as `lft_stat`.
- `vld` out 1: one-cycle pulse when new results are registered.

## Operation
- Free-running frame counter `frm_cnt`, PERIOD_BITS wide, counts 0..1023 and wraps. It is shared by both sides.
- Per side, two 11-bit high-time counters, `hf` (fwd) and `hr` (rev). Each increments on every cycle its pin is high. The width covers the value 1024.
- At frame end (`frm_cnt == 1023`), the sample of that cycle is included. Counters then clear for the next frame. Decode per side, first match wins:
  - `hf == 1024 && hr == 1024`: brake / zero command. Output 11'h000, stat BRAKE.
  - `hf == 0 && hr == 0`: idle (generator held in reset or coasting). Output 11'h000, stat IDLE.
  - `hr == 0`: forward. Output {1'b0, min(hf,1023)}, stat OK.
  - `hf == 0`: reverse. Output {1'b1, min(hr,1023)}, stat OK.
  - Otherwise (both pins active in the frame, not full brake): output holds its previous value, stat FAULT.
- Saturation: a count of 1024 on a single pin decodes as magnitude 1023.
- The decode does not depend on the generator's counter phase: for a constant duty, any 1024-cycle window contains exactly `duty` high cycles.
- If the duty changes mid-frame, the reported magnitude is the blend (the total high count). The result is exact from the next full frame onward.
- A direction change mid-frame puts both pins active in the same frame. This reports FAULT for at most one frame.
- Magnitude 0 with bit 10 = 1 is never produced.

## Timing
- Reset values: `lft = rht = 0`, `lft_stat = rht_stat = 0`, `vld = 0`. All counters are cleared.
- The frame counter starts at 0 in the first cycle after `rst_n` rises.
- Results register on the edge where `frm_cnt` wraps from 1023 to 0. `vld` is high during the cycle with `frm_cnt == 0`.
- The first `vld` occurs 1024 cycles after reset release, then every 1024 cycles.
- Outputs are stable between `vld` pulses.
- Reset asserted mid-frame discards the partial frame. No `vld` is produced for it.
- Pin-to-count latency is 0 cycles without the synchronizer and 2 cycles with it. Frame boundaries are unaffected by the synchronizer.

## Configuration
- `MOTOR_DEC_SYNC_EN` defined: each of the four pins passes through a 2-flop synchronizer, reset to 0, before counting. Use this for pins sourced off-clock or off-chip.
- `MOTOR_DEC_SYNC_EN` undefined: pins are sampled directly, for same-clock on-chip monitoring. A frame measured right after reset then includes the generator's post-reset edges with no extra delay.

## Structure
- Shared package `motor_pkg`:
  - `CMD_W = 11`
  - `MAG_W = 10`
  - `typedef enum logic [1:0] {ST_OK, ST_BRAKE, ST_IDLE, ST_FAULT} mot_stat_t`
- Sub-module `pwm_side_decode`, instantiated twice (left and right). It holds the `hf`/`hr` counters and decode logic, and takes `frame_end` as an input.
- Top level holds the frame counter, the optional synchronizers, and `vld` generation.

## Test plan
- Drive a reference generator with lft = 11'h100 (fwd 256) and rht = 11'h4C8 (rev 200) -> from the second `vld`: `lft = 11'h100`, `rht = 11'h4C8`, both stat OK.
- Command magnitude 0 on both sides (both pins held high) -> `lft = rht = 0`, stat BRAKE.
- Hold all pins low -> output 0, stat IDLE.
- Hold `fwd_lft` high for a full frame -> `lft = 11'h3FF`, stat OK.
- Step lft from fwd 300 to rev 300 mid-frame -> one frame with `lft_stat` FAULT and `lft` unchanged. Next frame: `lft = 11'h52C`, stat OK.
- Assert `rst_n` low at `frm_cnt == 500`, release -> outputs 0 immediately; the next `vld` arrives exactly 1024 cycles after release.
